// File: rtl/abv_stream_demux.sv
`default_nettype none
// ============================================================================
// Module      : abv_stream_demux
// Description : 1-to-2 valid/ready stream demultiplexer. A per-beat select
//               bit steers each input beat into a one-entry registered
//               buffer on out0 or out1. Each output keeps a saturating
//               count of completed transfers.
//               Optional macro ABV_STREAM_DEMUX_CHECKS_EN compiles in the
//               immediate assertions and the sticky X-detect flag x_err.
// Revision    : 1.0 - initial release
// ============================================================================
module abv_stream_demux #(
   parameter int DW = 8,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_sel,
   input  logic [DW-1:0] in_data,
   output logic          out0_valid,
   input  logic          out0_ready,
   output logic [DW-1:0] out0_data,
   output logic          out1_valid,
   input  logic          out1_ready,
   output logic [DW-1:0] out1_data,
   output logic [CW-1:0] xfer_cnt0,
   output logic [CW-1:0] xfer_cnt1,
   output logic          x_err
);

   localparam logic [CW-1:0] C_CNT_MAX = {CW{1'b1}};

   // Buffer state: the valid bit is the whole EMPTY/FULL state per output.
   logic          out0_valid_q, out0_valid_d;
   logic          out1_valid_q, out1_valid_d;
   logic [DW-1:0] out0_data_q,  out0_data_d;
   logic [DW-1:0] out1_data_q,  out1_data_d;
   logic [CW-1:0] xfer_cnt0_q,  xfer_cnt0_d;
   logic [CW-1:0] xfer_cnt1_q,  xfer_cnt1_d;

   logic w_sel_ok;
   logic w_load0, w_load1;
   logic w_drain0, w_drain1;

`ifdef ABV_STREAM_DEMUX_CHECKS_EN
   // An unknown select must never steer a beat anywhere.
   assign w_sel_ok = (in_sel === 1'b0) || (in_sel === 1'b1);
`else
   assign w_sel_ok = 1'b1;
`endif

   // Ready follows the buffer the current beat is aimed at; a FULL buffer
   // can still accept when it is draining in the same cycle.
   always_comb begin
      in_ready = 1'b0;
      if (w_sel_ok) begin
         in_ready = in_sel ? (!out1_valid_q || out1_ready)
                           : (!out0_valid_q || out0_ready);
      end
   end

   assign w_load0  = in_valid && in_ready && w_sel_ok && !in_sel;
   assign w_load1  = in_valid && in_ready && w_sel_ok &&  in_sel;
   assign w_drain0 = out0_valid_q && out0_ready;
   assign w_drain1 = out1_valid_q && out1_ready;

   // Next-state for both buffers and counters; load wins over drain.
   always_comb begin
      out0_valid_d = out0_valid_q;
      out1_valid_d = out1_valid_q;
      out0_data_d  = out0_data_q;
      out1_data_d  = out1_data_q;
      xfer_cnt0_d  = xfer_cnt0_q;
      xfer_cnt1_d  = xfer_cnt1_q;

      if (w_load0) begin
         out0_valid_d = 1'b1;
         out0_data_d  = in_data;
      end else if (w_drain0) begin
         out0_valid_d = 1'b0;
      end

      if (w_load1) begin
         out1_valid_d = 1'b1;
         out1_data_d  = in_data;
      end else if (w_drain1) begin
         out1_valid_d = 1'b0;
      end

      if (w_drain0 && (xfer_cnt0_q != C_CNT_MAX)) begin
         xfer_cnt0_d = xfer_cnt0_q + 1'b1;
      end
      if (w_drain1 && (xfer_cnt1_q != C_CNT_MAX)) begin
         xfer_cnt1_d = xfer_cnt1_q + 1'b1;
      end
   end

   // State registers; reset drops any beat in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out0_valid_q <= 1'b0;
         out1_valid_q <= 1'b0;
         out0_data_q  <= '0;
         out1_data_q  <= '0;
         xfer_cnt0_q  <= '0;
         xfer_cnt1_q  <= '0;
      end else begin
         out0_valid_q <= out0_valid_d;
         out1_valid_q <= out1_valid_d;
         out0_data_q  <= out0_data_d;
         out1_data_q  <= out1_data_d;
         xfer_cnt0_q  <= xfer_cnt0_d;
         xfer_cnt1_q  <= xfer_cnt1_d;
      end
   end

   assign out0_valid = out0_valid_q;
   assign out1_valid = out1_valid_q;
   assign out0_data  = out0_data_q;
   assign out1_data  = out1_data_q;
   assign xfer_cnt0  = xfer_cnt0_q;
   assign xfer_cnt1  = xfer_cnt1_q;

`ifdef ABV_STREAM_DEMUX_CHECKS_EN
   logic          x_err_q;
   logic          stall0_q, stall1_q;
   logic [DW-1:0] prev_data0_q, prev_data1_q;
   logic [CW-1:0] prev_cnt0_q, prev_cnt1_q;

   // Sticky X flag: any unknown on a valid beat's control or payload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_err_q <= 1'b0;
      end else if (in_valid && ((^in_sel === 1'bx) || (^in_data === 1'bx))) begin
         x_err_q <= 1'b1;
      end
   end

   assign x_err = x_err_q;

   // Protocol checks: X on valid beats, stall stability, monotonic counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall0_q     <= 1'b0;
         stall1_q     <= 1'b0;
         prev_data0_q <= '0;
         prev_data1_q <= '0;
         prev_cnt0_q  <= '0;
         prev_cnt1_q  <= '0;
      end else begin
         if (in_valid) begin
            a_sel_known : assert (^in_sel !== 1'bx)
               else $error("abv_stream_demux: in_sel is X/Z while in_valid");
            a_data_known : assert (^in_data !== 1'bx)
               else $error("abv_stream_demux: in_data is X/Z while in_valid");
         end
         if (stall0_q) begin
            a_stall0 : assert (out0_valid_q && (out0_data_q == prev_data0_q))
               else $error("abv_stream_demux: out0 changed during stall");
         end
         if (stall1_q) begin
            a_stall1 : assert (out1_valid_q && (out1_data_q == prev_data1_q))
               else $error("abv_stream_demux: out1 changed during stall");
         end
         a_cnt0_mono : assert (xfer_cnt0_q >= prev_cnt0_q)
            else $error("abv_stream_demux: xfer_cnt0 decremented");
         a_cnt1_mono : assert (xfer_cnt1_q >= prev_cnt1_q)
            else $error("abv_stream_demux: xfer_cnt1 decremented");
         stall0_q     <= out0_valid_q && !out0_ready;
         stall1_q     <= out1_valid_q && !out1_ready;
         prev_data0_q <= out0_data_q;
         prev_data1_q <= out1_data_q;
         prev_cnt0_q  <= xfer_cnt0_q;
         prev_cnt1_q  <= xfer_cnt1_q;
      end
   end
`else
   assign x_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_abv_stream_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_abv_stream_demux
// Description : Directed self-checking bench for abv_stream_demux. A CW=8
//               instance covers routing, backpressure, interleave and reset;
//               a CW=2 instance covers counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_abv_stream_demux;

   logic       clk;
   logic       rst_n;

   // Main instance (CW=8)
   logic       in_valid, in_ready, in_sel;
   logic [7:0] in_data;
   logic       out0_valid, out0_ready, out1_valid, out1_ready;
   logic [7:0] out0_data, out1_data;
   logic [7:0] xfer_cnt0, xfer_cnt1;
   logic       x_err;

   // Saturation instance (CW=2)
   logic       s_in_valid, s_in_ready, s_in_sel;
   logic [7:0] s_in_data;
   logic       s_out0_valid, s_out0_ready, s_out1_valid, s_out1_ready;
   logic [7:0] s_out0_data, s_out1_data;
   logic [1:0] s_xfer_cnt0, s_xfer_cnt1;
   logic       s_x_err;

   int n_total;
   int n_bad;

   abv_stream_demux #(.DW(8), .CW(8)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sel     (in_sel),
      .in_data    (in_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out0_data  (out0_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data),
      .xfer_cnt0  (xfer_cnt0),
      .xfer_cnt1  (xfer_cnt1),
      .x_err      (x_err)
   );

   abv_stream_demux #(.DW(8), .CW(2)) u_dut_sat (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (s_in_valid),
      .in_ready   (s_in_ready),
      .in_sel     (s_in_sel),
      .in_data    (s_in_data),
      .out0_valid (s_out0_valid),
      .out0_ready (s_out0_ready),
      .out0_data  (s_out0_data),
      .out1_valid (s_out1_valid),
      .out1_ready (s_out1_ready),
      .out1_data  (s_out1_data),
      .xfer_cnt0  (s_xfer_cnt0),
      .xfer_cnt1  (s_xfer_cnt1),
      .x_err      (s_x_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_d;

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst_n = 1'b0;
      in_valid = 1'b0; in_sel = 1'b0; in_data = 8'h00;
      out0_ready = 1'b0; out1_ready = 1'b0;
      s_in_valid = 1'b0; s_in_sel = 1'b0; s_in_data = 8'h00;
      s_out0_ready = 1'b0; s_out1_ready = 1'b0;

      // Reset then idle
      tick();
      tick();
      chk("rst_v0",   {31'd0, out0_valid}, 32'd0);
      chk("rst_v1",   {31'd0, out1_valid}, 32'd0);
      chk("rst_d0",   {24'd0, out0_data},  32'd0);
      chk("rst_cnt0", {24'd0, xfer_cnt0},  32'd0);
      chk("rst_cnt1", {24'd0, xfer_cnt1},  32'd0);
      chk("rst_xerr", {31'd0, x_err},      32'd0);
      rst_n = 1'b1;
      tick();
      in_sel = 1'b0; #1;
      chk("idle_rdy_s0", {31'd0, in_ready}, 32'd1);
      in_sel = 1'b1; #1;
      chk("idle_rdy_s1", {31'd0, in_ready}, 32'd1);

      // Single route to out1
      in_valid = 1'b1; in_sel = 1'b1; in_data = 8'hA5;
      out0_ready = 1'b1; out1_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("route_v1", {31'd0, out1_valid}, 32'd1);
      chk("route_d1", {24'd0, out1_data},  32'hA5);
      chk("route_v0", {31'd0, out0_valid}, 32'd0);
      tick();
      chk("route_v1_drn", {31'd0, out1_valid}, 32'd0);
      chk("route_cnt1",   {24'd0, xfer_cnt1},  32'd1);
      chk("route_d1_hold",{24'd0, out1_data},  32'hA5);

      // Backpressure on out0
      out0_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h11;
      #1;
      chk("bp_rdy_first", {31'd0, in_ready}, 32'd1);
      tick();
      in_data = 8'h22;
      #1;
      chk("bp_rdy_full", {31'd0, in_ready},  32'd0);
      chk("bp_d0_first", {24'd0, out0_data}, 32'h11);
      tick();
      chk("bp_d0_stall", {24'd0, out0_data}, 32'h11);
      chk("bp_v0_stall", {31'd0, out0_valid},32'd1);
      chk("bp_cnt0_stall",{24'd0, xfer_cnt0},32'd0);
      out0_ready = 1'b1;
      #1;
      chk("bp_rdy_release", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("bp_d0_second", {24'd0, out0_data},  32'h22);
      chk("bp_v0_second", {31'd0, out0_valid}, 32'd1);
      chk("bp_cnt0_one",  {24'd0, xfer_cnt0},  32'd1);
      tick();
      chk("bp_cnt0_two",  {24'd0, xfer_cnt0},  32'd2);
      chk("bp_v0_empty",  {31'd0, out0_valid}, 32'd0);

      // Interleave 0,1,0,1 at full rate
      out0_ready = 1'b1; out1_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1;
         in_sel   = (i % 2 == 0);
         in_data  = 8'(i);
         #1;
         chk("il_rdy", {31'd0, in_ready}, 32'd1);
         tick();
         exp_d = 8'(i);
         if (i % 2 == 0) begin
            chk("il_v1", {31'd0, out1_valid}, 32'd1);
            chk("il_d1", {24'd0, out1_data},  {24'd0, exp_d});
         end else begin
            chk("il_v0", {31'd0, out0_valid}, 32'd1);
            chk("il_d0", {24'd0, out0_data},  {24'd0, exp_d});
         end
      end
      in_valid = 1'b0;
      tick();
      chk("il_cnt0", {24'd0, xfer_cnt0}, 32'd4);
      chk("il_cnt1", {24'd0, xfer_cnt1}, 32'd3);
      chk("il_v0_end", {31'd0, out0_valid}, 32'd0);
      chk("il_v1_end", {31'd0, out1_valid}, 32'd0);

      // Reset mid-operation drops the in-flight beat and the counters
      out1_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h77;
      tick();
      in_valid = 1'b0;
      chk("mr_v1_loaded", {31'd0, out1_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_v1_async",  {31'd0, out1_valid}, 32'd0);
      chk("mr_cnt0_async",{24'd0, xfer_cnt0},  32'd0);
      chk("mr_cnt1_async",{24'd0, xfer_cnt1},  32'd0);
      tick();
      rst_n = 1'b1;
      in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h3C;
      tick();
      in_valid = 1'b0;
      chk("mr_first_v0", {31'd0, out0_valid}, 32'd1);
      chk("mr_first_d0", {24'd0, out0_data},  32'h3C);
      chk("xerr_clean",  {31'd0, x_err},      32'd0);

      // Saturation on the CW=2 instance: counts 1,2,3,3,3
      s_out0_ready = 1'b1;
      s_in_valid = 1'b1; s_in_sel = 1'b0; s_in_data = 8'h5A;
      tick();
      chk("sat_cnt_load", {30'd0, s_xfer_cnt0}, 32'd0);
      for (int k = 1; k <= 5; k++) begin
         if (k == 5) s_in_valid = 1'b0;
         tick();
         chk("sat_cnt0", {30'd0, s_xfer_cnt0}, (k > 3) ? 32'd3 : 32'(k));
      end
      s_out0_ready = 1'b0;

`ifdef ABV_STREAM_DEMUX_CHECKS_EN
      // X on select: flagged, nothing loads, flag is sticky until reset
      tick();
      in_valid = 1'b1; in_sel = 1'bx; in_data = 8'h5A;
      out0_ready = 1'b1; out1_ready = 1'b1;
      tick();
      in_valid = 1'b0; in_sel = 1'b0;
      chk("x_err_set", {31'd0, x_err},      32'd1);
      chk("x_no_v0",   {31'd0, out0_valid}, 32'd0);
      chk("x_no_v1",   {31'd0, out1_valid}, 32'd0);
      tick();
      chk("x_err_sticky", {31'd0, x_err}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("x_err_clr", {31'd0, x_err}, 32'd0);
      tick();
      rst_n = 1'b1;
`endif

      tick();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
